// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Streams configuration words LSB-first into a ccff shift chain,
//               with an optional read-back verify pass on ccff_tail.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_err_idx
);

    localparam int BC_W  = $clog2(WORD_W + 1);
    localparam int IDX_W = CNT_W + 1;

    localparam logic [IDX_W-1:0] c_chain_len = IDX_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] c_word_w    = IDX_W'(WORD_W);
    localparam logic [BC_W-1:0]  c_word_w_bc = BC_W'(WORD_W);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_verify = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]        r_state;
    logic              r_verify;
    logic [WORD_W-1:0] r_buf;
    logic [BC_W-1:0]   r_buf_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_mismatch;
    logic [CNT_W-1:0]  r_mismatch_cnt;
    logic [CNT_W-1:0]  r_first_err_idx;

    logic              w_active;
    logic              w_shift;
    logic              w_accept;
    logic              w_last;
    logic              w_miss;
    logic [IDX_W-1:0]  w_remain;
    logic [BC_W-1:0]   w_take;

    assign w_active = (r_state == c_st_load) || (r_state == c_st_verify);
    assign w_shift  = w_active && (r_buf_cnt != '0);
    assign s_ready  = w_active && (r_buf_cnt == '0) && (r_bit_idx < c_chain_len);
    assign w_accept = s_valid && s_ready;
    assign w_remain = c_chain_len - r_bit_idx;
    // A final partial word only loads as many bits as the chain still needs.
    assign w_take   = (w_remain >= c_word_w) ? c_word_w_bc : w_remain[BC_W-1:0];
    assign w_last   = w_shift && (r_bit_idx == c_chain_len - IDX_W'(1));
    assign w_miss   = (r_state == c_st_verify) && w_shift && (ccff_tail != r_buf[0]);

    assign ccff_head     = w_shift & r_buf[0];
    assign chain_clk_en  = w_shift;
    assign busy          = r_busy;
    assign done          = r_done;
    assign mismatch      = r_mismatch;
    assign mismatch_cnt  = r_mismatch_cnt;
    assign first_err_idx = r_first_err_idx;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state         <= c_st_idle;
            r_verify        <= 1'b0;
            r_buf           <= '0;
            r_buf_cnt       <= '0;
            r_bit_idx       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_mismatch      <= 1'b0;
            r_mismatch_cnt  <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state         <= c_st_load;
                        r_busy          <= 1'b1;
                        r_verify        <= verify;
                        r_buf_cnt       <= '0;
                        r_bit_idx       <= '0;
                        r_mismatch      <= 1'b0;
                        r_mismatch_cnt  <= '0;
                        r_first_err_idx <= '0;
                    end
                end
                c_st_load, c_st_verify: begin
                    if (w_accept) begin
                        r_buf     <= s_data;
                        r_buf_cnt <= w_take;
                    end else if (w_shift) begin
                        r_buf     <= r_buf >> 1;
                        r_buf_cnt <= r_buf_cnt - BC_W'(1);
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                        if (w_miss) begin
                            r_mismatch <= 1'b1;
                            if (r_mismatch_cnt != '1) begin
                                r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                            end
                            if (!r_mismatch) begin
                                r_first_err_idx <= r_bit_idx[CNT_W-1:0];
                            end
                        end
                        if (w_last) begin
                            if ((r_state == c_st_load) && r_verify) begin
                                r_state   <= c_st_verify;
                                r_bit_idx <= '0;
                            end else begin
                                r_state <= c_st_done;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Directed bench for ccff_chain_loader driving a 20-flop chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int CW = 16;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b1;
    logic          start    = 1'b0;
    logic          verify   = 1'b0;
    logic [WW-1:0] s_data   = '0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          chain_clk_en;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] first_err_idx;

    logic [CL-1:0] chain = '0;
    int edges = 0, hs = 0, dones = 0, busy_cyc = 0;
    int errors = 0, checks = 0;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .verify(verify),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .chain_clk_en(chain_clk_en),
        .busy(busy), .done(done), .mismatch(mismatch),
        .mismatch_cnt(mismatch_cnt), .first_err_idx(first_err_idx)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: head enters chain[0], tail is chain[CL-1].
    assign ccff_tail = chain[CL-1];
    always @(posedge prog_clk) if (chain_clk_en) chain <= {chain[CL-2:0], ccff_head};

    always @(posedge prog_clk) begin
        if (chain_clk_en) edges++;
        if (s_valid && s_ready) hs++;
        if (done) dones++;
        if (busy) busy_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic v);
        start = 1'b1; verify = v;
        @(negedge prog_clk);
        start = 1'b0; verify = 1'b0;
    endtask

    // Presents three words (low byte first); optional stall after the first word.
    task automatic feed(input logic [23:0] words, input int gap);
        int budget;
        logic bad;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = words[8*k +: 8];
            budget  = 0;
            while (!s_ready && budget < 100) begin
                @(negedge prog_clk);
                budget++;
            end
            if (!s_ready) begin
                checks++; errors++;
                $display("FAIL feed_handshake word %0d: s_ready actual=0 required=1", k);
                s_valid = 1'b0;
                return;
            end
            @(negedge prog_clk);
            s_valid = 1'b0;
            if (k == 0 && gap > 0) begin
                repeat (WW) @(negedge prog_clk);
                bad = 1'b0;
                repeat (gap) begin
                    if (chain_clk_en !== 1'b0 || ccff_head !== 1'b0) bad = 1'b1;
                    @(negedge prog_clk);
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL stall_gap: chain_clk_en actual=active required=0");
                end
            end
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy && budget < 200) begin
            @(negedge prog_clk);
            budget++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy actual=%b required=0", busy);
        end
    endtask

    task automatic test_reset();
        pReset = 1'b1;
        repeat (3) @(negedge prog_clk);
        pReset = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready actual=%b required=0", s_ready); end
        checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL reset_head actual=%b required=0", ccff_head); end
        checks++; if (chain_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en actual=%b required=0", chain_clk_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch actual=%b required=0", mismatch); end
        checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt actual=%0d required=0", mismatch_cnt); end
        checks++; if (first_err_idx !== 16'd0) begin errors++; $display("FAIL reset_first_idx actual=%0d required=0", first_err_idx); end
    endtask

    task automatic test_load();
        int e0, h0, d0, b0;
        e0 = edges; h0 = hs; d0 = dones; b0 = busy_cyc;
        pulse_start(1'b0);
        feed(24'h0F3CA5, 0);
        wait_idle();
        checks++; if (chain !== 20'hA53CF) begin errors++; $display("FAIL load_chain actual=%h required=a53cf", chain); end
        checks++; if (edges - e0 != 20) begin errors++; $display("FAIL load_edges actual=%0d required=20", edges - e0); end
        checks++; if (hs - h0 != 3) begin errors++; $display("FAIL load_handshakes actual=%0d required=3", hs - h0); end
        checks++; if (dones - d0 != 1) begin errors++; $display("FAIL load_done actual=%0d required=1", dones - d0); end
        checks++; if (busy_cyc - b0 != 24) begin errors++; $display("FAIL load_latency actual=%0d required=24", busy_cyc - b0); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL load_mismatch actual=%b required=0", mismatch); end
    endtask

    task automatic test_verify();
        int e0, d0, b0;
        e0 = edges; d0 = dones; b0 = busy_cyc;
        pulse_start(1'b1);
        feed(24'h0F3CA5, 0);
        feed(24'h0F3CA5, 0);
        wait_idle();
        checks++; if (edges - e0 != 40) begin errors++; $display("FAIL verify_edges actual=%0d required=40", edges - e0); end
        checks++; if (dones - d0 != 1) begin errors++; $display("FAIL verify_done actual=%0d required=1", dones - d0); end
        checks++; if (busy_cyc - b0 != 47) begin errors++; $display("FAIL verify_latency actual=%0d required=47", busy_cyc - b0); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL verify_mismatch actual=%b required=0", mismatch); end
        checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL verify_cnt actual=%0d required=0", mismatch_cnt); end
    endtask

    task automatic test_mismatch();
        pulse_start(1'b1);
        feed(24'h0F3CA5, 0);
        feed(24'h0F3DA5, 0);
        wait_idle();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_flag actual=%b required=1", mismatch); end
        checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL mm_cnt actual=%0d required=1", mismatch_cnt); end
        checks++; if (first_err_idx !== 16'd8) begin errors++; $display("FAIL mm_first_idx actual=%0d required=8", first_err_idx); end
    endtask

    task automatic test_stall();
        int e0;
        e0 = edges;
        pulse_start(1'b0);
        feed(24'h0F3CA5, 5);
        wait_idle();
        checks++; if (chain !== 20'hA53CF) begin errors++; $display("FAIL stall_chain actual=%h required=a53cf", chain); end
        checks++; if (edges - e0 != 20) begin errors++; $display("FAIL stall_edges actual=%0d required=20", edges - e0); end
    endtask

    task automatic test_reset_mid_load();
        int e0, d0, budget;
        e0 = edges; d0 = dones; budget = 0;
        pulse_start(1'b0);
        s_valid = 1'b1; s_data = 8'hA5;
        while (edges - e0 < 10 && budget < 200) begin
            @(negedge prog_clk);
            budget++;
        end
        checks++; if (edges - e0 != 10) begin errors++; $display("FAIL rst_mid_reach actual=%0d required=10", edges - e0); end
        pReset = 1'b1;
        @(negedge prog_clk);
        pReset = 1'b0; s_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy actual=%b required=0", busy); end
        checks++; if (chain_clk_en !== 1'b0) begin errors++; $display("FAIL rst_mid_clk_en actual=%b required=0", chain_clk_en); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_s_ready actual=%b required=0", s_ready); end
        repeat (3) @(negedge prog_clk);
        checks++; if (dones - d0 != 0) begin errors++; $display("FAIL rst_mid_done actual=%0d required=0", dones - d0); end
        e0 = edges;
        pulse_start(1'b0);
        feed(24'h06C35A, 0);
        wait_idle();
        checks++; if (chain !== 20'h5AC36) begin errors++; $display("FAIL rst_reload_chain actual=%h required=5ac36", chain); end
        checks++; if (edges - e0 != 20) begin errors++; $display("FAIL rst_reload_edges actual=%0d required=20", edges - e0); end
    endtask

    task automatic test_start_while_busy();
        int e0, d0;
        pulse_start(1'b1);
        feed(24'h0F3CA5, 0);
        feed(24'h0F3DA5, 0);
        wait_idle();
        repeat (4) @(negedge prog_clk);
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL sticky_idle actual=%b required=1", mismatch); end
        e0 = edges; d0 = dones;
        pulse_start(1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL clear_on_start actual=%b required=0", mismatch); end
        feed(24'h0F3CA5, 0);
        pulse_start(1'b0);
        feed(24'h0F3CA5, 0);
        wait_idle();
        checks++; if (edges - e0 != 40) begin errors++; $display("FAIL busy_start_edges actual=%0d required=40", edges - e0); end
        checks++; if (dones - d0 != 1) begin errors++; $display("FAIL busy_start_done actual=%0d required=1", dones - d0); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL busy_start_mismatch actual=%b required=0", mismatch); end
    endtask

    initial begin
        @(negedge prog_clk);
        test_reset();
        test_load();
        test_verify();
        test_mismatch();
        test_stall();
        test_reset_mid_load();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
